// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants for the regfile_sb register file slice.
//   DEF_DATA_W  : default data bits per register
//   DEF_ADDR_W  : default register address bits (depth = 2**ADDR_W)
//   DEF_NUM_RD  : default number of read ports
//   MAX_NUM_RD  : largest supported number of read ports
//   DEF_DBG_REG : default register index mirrored onto the debug tap
package regfile_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_ADDR_W  = 5;
  localparam int unsigned DEF_NUM_RD  = 2;
  localparam int unsigned MAX_NUM_RD  = 4;
  localparam int unsigned DEF_DBG_REG = 20;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one pending bit per register, tracking in-flight
// producers.
//   clock        : rising-edge clock
//   ctrl_reset_n : synchronous active-low reset, clears every pending bit
//   set_en/addr  : issue; marks set_addr pending
//   clr_en/addr  : write-back; clears clr_addr
//   pending      : current pending bit per register
// A set and a clear of the same address on one edge leave the bit set.
// With ZERO_REG != 0, register 0 can never become pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     ctrl_reset_n,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  output logic [(1<<ADDR_W)-1:0]   pending
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Clear first, then set: a new issue overrides a same-edge write-back.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[set_addr] = 1'b1;
    if (ZERO_REG != 0) pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) pending_q <= '0;
    else               pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-read-port register file with issue/write-back
// scoreboard and a registered debug tap.
//   clock            : rising-edge clock
//   ctrl_reset_n     : synchronous active-low reset (regs, pending, debug tap)
//   ctrl_writeEnable : write data_writeReg to ctrl_writeReg this edge
//   ctrl_writeReg    : write address
//   data_writeReg    : write data
//   ctrl_issueEnable : mark ctrl_issueReg pending this edge
//   ctrl_issueReg    : issue address
//   ctrl_readReg     : packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   data_readReg     : packed read data, port p at [p*DATA_W +: DATA_W]
//   busy_readReg     : per-port pending flag of the addressed register
//   data_dbg         : register DBG_REG, delayed by one edge
// Optional feature macro REGFILE_BYPASS_EN: a read of the register being
// written this cycle returns the incoming write data, and its busy flag
// reflects only a same-cycle issue to that register. Without the macro,
// reads see stored state only.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned DBG_REG  = DEF_DBG_REG
) (
  input  logic                     clock,
  input  logic                     ctrl_reset_n,
  input  logic                     ctrl_writeEnable,
  input  logic [ADDR_W-1:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0]        data_writeReg,
  input  logic                     ctrl_issueEnable,
  input  logic [ADDR_W-1:0]        ctrl_issueReg,
  input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
  output logic [NUM_RD*DATA_W-1:0] data_readReg,
  output logic [NUM_RD-1:0]        busy_readReg,
  output logic [DATA_W-1:0]        data_dbg
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);

  if (DBG_REG >= DEPTH) begin : g_bad_dbg_reg
    $error("regfile_sb: DBG_REG (%0d) must be below depth (%0d)", DBG_REG, DEPTH);
  end
  if (NUM_RD < 1 || NUM_RD > MAX_NUM_RD) begin : g_bad_num_rd
    $error("regfile_sb: NUM_RD (%0d) must be within 1..%0d", NUM_RD, MAX_NUM_RD);
  end

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] data_dbg_q;
  logic [DATA_W-1:0] data_dbg_d;
  logic [DEPTH-1:0]  pending;
  logic              write_ok;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .set_en       (ctrl_issueEnable),
    .set_addr     (ctrl_issueReg),
    .clr_en       (ctrl_writeEnable),
    .clr_addr     (ctrl_writeReg),
    .pending      (pending)
  );

  assign write_ok = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));

  always_comb begin
    regs_d = regs_q;
    if (write_ok) regs_d[ctrl_writeReg] = data_writeReg;
    data_dbg_d = regs_q[DBG_IDX];
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      regs_q     <= '{default: '0};
      data_dbg_q <= '0;
    end else begin
      regs_q     <= regs_d;
      data_dbg_q <= data_dbg_d;
    end
  end

  assign data_dbg = data_dbg_q;

  always_comb begin
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;
    data_readReg = '0;
    busy_readReg = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      raddr = ctrl_readReg[p*ADDR_W +: ADDR_W];
      rdata = regs_q[raddr];
      rbusy = pending[raddr];
`ifdef REGFILE_BYPASS_EN
      if (ctrl_writeEnable && (ctrl_writeReg == raddr)) begin
        rdata = data_writeReg;
        rbusy = ctrl_issueEnable && (ctrl_issueReg == raddr);
      end
`endif
      // Zero register override last so bypass can never leak through it.
      if ((ZERO_REG != 0) && (raddr == '0)) begin
        rdata = '0;
        rbusy = 1'b0;
      end
      data_readReg[p*DATA_W +: DATA_W] = rdata;
      busy_readReg[p]                  = rbusy;
    end
  end

endmodule : regfile_sb

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, data bits per register.
REQ-002 Parameter ADDR_W, default 5, register address bits; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 reads 0 and ignores writes and issues.
REQ-005 Parameter DBG_REG, default 20, register index driven onto the debug tap.
REQ-006 clock  in  1  single clock; all state updates on rising edge.
REQ-007 ctrl_reset_n  in  1  reset, synchronous, active-low.
REQ-008 ctrl_writeEnable  in  1  commit data_writeReg to ctrl_writeReg this edge.
REQ-009 ctrl_writeReg  in  ADDR_W  write address.
REQ-010 data_writeReg  in  DATA_W  write data.
REQ-011 ctrl_issueEnable  in  1  mark ctrl_issueReg as pending (in-flight producer).
REQ-012 ctrl_issueReg  in  ADDR_W  issue address.
REQ-013 ctrl_readReg  in  NUM_RD*ADDR_W  packed read addresses, port p at bits [p*ADDR_W +: ADDR_W].
REQ-014 data_readReg  out  NUM_RD*DATA_W  packed read data, port p at bits [p*DATA_W +: DATA_W].
REQ-015 busy_readReg  out  NUM_RD  per-port pending flag of addressed register.
REQ-016 data_dbg  out  DATA_W  registered copy of register DBG_REG.

Function
REQ-017 Reads combinational: data_readReg port p = reg[ctrl_readReg p]; all ports independent, same address on several ports allowed.
REQ-018 Write: on edge with ctrl_writeEnable=1, reg[ctrl_writeReg] <= data_writeReg; no other register changes.
REQ-019 ZERO_REG=1: write or issue to address 0 ignored; reads of 0 return 0, busy 0.
REQ-020 Scoreboard: pending[a] set on edge with ctrl_issueEnable=1 and ctrl_issueReg=a.
REQ-021 pending[a] cleared on edge with ctrl_writeEnable=1 and ctrl_writeReg=a.
REQ-022 Same edge issue and write to same address: pending stays/becomes 1 (new issue wins); data still written.
REQ-023 Issue to already-pending register: stays 1, no error; write to non-pending register: written, pending stays 0.
REQ-024 busy_readReg p = pending[ctrl_readReg p] (modified per REQ-029).
REQ-025 data_dbg <= reg[DBG_REG] every edge; one-cycle latency after write.
REQ-026 Parameter DBG_REG >= depth is illegal; elaboration shall fail via assertion.

Reset
REQ-027 Edge with ctrl_reset_n=0: all registers 0, all pending 0, data_dbg 0; write and issue in that cycle ignored.
REQ-028 Reset asserted mid-sequence discards all pending state; first post-reset edge accepts writes/issues normally.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: read port whose address equals ctrl_writeReg with ctrl_writeEnable=1 (and not zero reg) returns data_writeReg and busy = 0 unless ctrl_issueEnable targets the same address that cycle (then busy = 1).
REQ-030 Macro undefined: reads return stored value (old data) and busy reflects stored pending only; no combinational path from write/issue inputs to read outputs.

Structure
REQ-031 Package regfile_pkg holds default DATA_W/ADDR_W/NUM_RD constants and the DBG_REG default index.
REQ-032 Sub-module regfile_scoreboard owns pending bits (set/clear/priority, reset); storage and read muxes live in regfile_sb.

Verification
REQ-033 Reset, write 0xDEADBEEF to r5, read r5 on port 0 and 1 next cycle -> both 0xDEADBEEF, busy 0.
REQ-034 Write 0x1234 to r0 -> read r0 returns 0; issue r0 -> busy 0.
REQ-035 Issue r7, then 3 cycles later write 0x55 to r7 -> busy 1 for those cycles, 0 after write edge; data 0x55.
REQ-036 Same cycle issue r9 and write 0xAA to r9 -> r9=0xAA, busy stays 1.
REQ-037 Write 0x77 to r3 while port 0 reads r3 same cycle -> 0x77 with REGFILE_BYPASS_EN, prior value without.
REQ-038 Write 0x3FF to r20 then assert ctrl_reset_n=0 mid-run -> data_dbg 0x3FF one cycle after write, all regs/pending/data_dbg 0 after reset edge.
